// File: rtl/keypad_matrix_responder_if.sv
// Key-press request handshake between a producer and the keypad responder.
interface keypad_matrix_responder_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_done;

   modport master (output key_valid, output key_code, input key_ready, input key_done);
   modport slave  (input key_valid, input key_code, output key_ready, output key_done);
endinterface

// File: rtl/keypad_matrix_responder.sv
// 4x4 membrane keypad model: answers the scanner's active-low column drive on the row lines,
// sequencing bounce-in, hold, bounce-out and gap for each requested key press.
module keypad_matrix_responder #(
   parameter int unsigned HOLD_CYCLES   = 50,
   parameter int unsigned BOUNCE_CYCLES = 8,
   parameter bit          BOUNCE_EN     = 1'b1,
   parameter int unsigned GAP_CYCLES    = 16,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [3:0]                 col,
   output logic [3:0]                 row,
   output logic                       contact,
   keypad_matrix_responder_if.slave   key
);

   localparam int unsigned MaxHb     = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
   localparam int unsigned MaxCycles = (MaxHb > GAP_CYCLES) ? MaxHb : GAP_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);
   localparam bit          UseBounce = BOUNCE_EN && (BOUNCE_CYCLES != 0);
   localparam bit          UseGap    = (GAP_CYCLES != 0);

   // Counter holds remaining cycles minus one, so each state lasts exactly its parameter.
   localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] BounceLoad = CntW'(BOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] GapLoad    = CntW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StBounceIn, StHold, StBounceOut, StGap} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [7:0]      lfsr_q;
   logic [7:0]      lfsr_shift;
   logic [1:0]      r_q;
   logic [1:0]      c_q;
   logic            contact_q;
   logic            ready_q;
   logic            done_q;
   logic [3:0]      row_q;

   // Fibonacci LFSR, taps 8,6,5,4.
   assign lfsr_shift = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         r_q       <= 2'd0;
         c_q       <= 2'd0;
         contact_q <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (key.key_valid) begin
                  r_q     <= key.key_code[3:2];
                  c_q     <= key.key_code[1:0];
                  ready_q <= 1'b0;
                  if (UseBounce) begin
                     state_q   <= StBounceIn;
                     cnt_q     <= BounceLoad;
                     contact_q <= lfsr_q[0];
                  end else begin
                     state_q   <= StHold;
                     cnt_q     <= HoldLoad;
                     contact_q <= 1'b1;
                  end
               end
            end
            StBounceIn: begin
               lfsr_q <= lfsr_shift;
               if (cnt_q == '0) begin
                  state_q   <= StHold;
                  cnt_q     <= HoldLoad;
                  contact_q <= 1'b1;
               end else begin
                  cnt_q     <= cnt_q - CntW'(1);
                  contact_q <= lfsr_shift[0];
               end
            end
            StHold: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else if (UseBounce) begin
                  state_q   <= StBounceOut;
                  cnt_q     <= BounceLoad;
                  contact_q <= lfsr_q[0];
               end else if (UseGap) begin
                  state_q   <= StGap;
                  cnt_q     <= GapLoad;
                  contact_q <= 1'b0;
               end else begin
                  state_q   <= StIdle;
                  contact_q <= 1'b0;
                  ready_q   <= 1'b1;
                  done_q    <= 1'b1;
               end
            end
            StBounceOut: begin
               lfsr_q <= lfsr_shift;
               if (cnt_q != '0) begin
                  cnt_q     <= cnt_q - CntW'(1);
                  contact_q <= lfsr_shift[0];
               end else if (UseGap) begin
                  state_q   <= StGap;
                  cnt_q     <= GapLoad;
                  contact_q <= 1'b0;
               end else begin
                  state_q   <= StIdle;
                  contact_q <= 1'b0;
                  ready_q   <= 1'b1;
                  done_q    <= 1'b1;
               end
            end
            StGap: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q   <= StIdle;
               contact_q <= 1'b0;
               ready_q   <= 1'b1;
            end
         endcase
      end
   end

   // Row follows col and contact one cycle later; other low columns do not block the pull.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_q <= 4'hF;
      end else begin
         row_q <= (contact_q && !col[c_q]) ? ~(4'b0001 << r_q) : 4'hF;
      end
   end

   assign row           = row_q;
   assign contact       = contact_q;
   assign key.key_ready = ready_q;
   assign key.key_done  = done_q;

endmodule
